// File: rtl/processor_boot_ctrl.sv
// processor_boot_ctrl: Moore sequencer that takes the processor through
// memory reset, image load, core reset, PC reset, a bounded or HALT-terminated
// run, and a final memory dump. All outputs are registered decodes of the
// state being entered, so every output matches the current state and is glitch-free.
module processor_boot_ctrl #(
  parameter int LOAD_CYCLES = 1,
  parameter int RUN_CYCLES  = 900,
  parameter int DUMP_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        HALT,
  output logic        mem_RESET,
  output logic        load_file,
  output logic        core_RESET,
  output logic        pc_RESET,
  output logic        pipe_ENABLE,
  output logic        dump_file,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] run_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RST,
    S_LOAD,
    S_CORE_RST,
    S_PC_RST,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  localparam logic [31:0] LOAD_LAST   = 32'(LOAD_CYCLES - 1);
  localparam logic [31:0] DUMP_LAST   = 32'(DUMP_CYCLES - 1);
  localparam logic [31:0] RUN_LIMIT   = 32'(RUN_CYCLES);
  localparam logic        RUN_BOUNDED = (RUN_CYCLES != 0);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_phase;
  logic [31:0] w_run_count_inc;
  logic        w_run_last;

  // Value run_count takes at the current RUN edge; reaching the limit ends the run.
  assign w_run_count_inc = run_count + 32'd1;
  assign w_run_last      = RUN_BOUNDED && (w_run_count_inc == RUN_LIMIT);

  // Next-state selection; HALT is only looked at in RUN, START only in IDLE/DONE.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves w_next_state unassigned and a latch is never inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:     if (START) w_next_state = S_MEM_RST;
      S_MEM_RST:  w_next_state = S_LOAD;
      S_LOAD:     if (r_phase == LOAD_LAST) w_next_state = S_CORE_RST;
      S_CORE_RST: w_next_state = S_PC_RST;
      S_PC_RST:   w_next_state = S_RUN;
      S_RUN:      if (HALT || w_run_last) w_next_state = S_DUMP;
      S_DUMP:     if (r_phase == DUMP_LAST) w_next_state = S_DONE;
      S_DONE:     if (!START) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // State, phase timer, run counter and registered output decode of the next state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: every control flop is on the asynchronous reset, so an abort drops pipe_ENABLE/dump_file without waiting for an edge.
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      run_count   <= '0;
      mem_RESET   <= 1'b0;
      load_file   <= 1'b0;
      core_RESET  <= 1'b0;
      pc_RESET    <= 1'b0;
      pipe_ENABLE <= 1'b0;
      dump_file   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, regardless of statement order.
      r_state <= w_next_state;

      // The phase timer restarts on every state entry and only advances in LOAD and DUMP.
      if (w_next_state != r_state) begin
        r_phase <= '0;
      end else if (r_state == S_LOAD || r_state == S_DUMP) begin
        r_phase <= r_phase + 32'd1;
      end

      // Cleared on entry to PC_RST, counts every RUN edge, holds elsewhere (wraps when unbounded).
      if (w_next_state == S_PC_RST && r_state != S_PC_RST) begin
        run_count <= '0;
      end else if (r_state == S_RUN) begin
        run_count <= w_run_count_inc;
      end

      mem_RESET   <= (w_next_state == S_MEM_RST);
      load_file   <= (w_next_state == S_LOAD);
      core_RESET  <= (w_next_state == S_CORE_RST);
      pc_RESET    <= (w_next_state == S_PC_RST);
      pipe_ENABLE <= (w_next_state == S_RUN);
      dump_file   <= (w_next_state == S_DUMP);
      BUSY        <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
      DONE        <= (w_next_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_processor_boot_ctrl.sv
// Bench for processor_boot_ctrl. Two instances: A (LOAD=2, RUN=5, DUMP=1)
// and B (LOAD=1, RUN=0 unbounded, DUMP=1). A timeline model, expressed as
// "cycle number since the START edge", predicts every output each cycle.
module tb_processor_boot_ctrl;

  localparam int L_A = 2, R_A = 5, D_A = 1;
  localparam int L_B = 1, R_B = 0, D_B = 1;

  logic CLK = 1'b0;
  logic RESET_N;
  logic start_a, halt_a, start_b, halt_b;

  logic mem_a, load_a, core_a, pc_a, pipe_a, dump_a, busy_a, done_a;
  logic mem_b, load_b, core_b, pc_b, pipe_b, dump_b, busy_b, done_b;
  logic [31:0] rc_a, rc_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  processor_boot_ctrl #(.LOAD_CYCLES(L_A), .RUN_CYCLES(R_A), .DUMP_CYCLES(D_A)) u_dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .START(start_a), .HALT(halt_a),
    .mem_RESET(mem_a), .load_file(load_a), .core_RESET(core_a), .pc_RESET(pc_a),
    .pipe_ENABLE(pipe_a), .dump_file(dump_a), .BUSY(busy_a), .DONE(done_a),
    .run_count(rc_a)
  );

  processor_boot_ctrl #(.LOAD_CYCLES(L_B), .RUN_CYCLES(R_B), .DUMP_CYCLES(D_B)) u_dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .START(start_b), .HALT(halt_b),
    .mem_RESET(mem_b), .load_file(load_b), .core_RESET(core_b), .pc_RESET(pc_b),
    .pipe_ENABLE(pipe_b), .dump_file(dump_b), .BUSY(busy_b), .DONE(done_b),
    .run_count(rc_b)
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // t = number of the cycle in effect, counting the cycle after the START edge as 1.
  // run_end = cycle number of the last pipe_ENABLE cycle, -1 while still running.
  typedef struct {
    bit          active;
    bit          done;
    int          t;
    int          run_end;
    logic [31:0] rc;
  } model_t;

  model_t m [2];
  int p_l [2] = '{L_A, L_B};
  int p_r [2] = '{R_A, R_B};
  int p_d [2] = '{D_A, D_B};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].active  = 1'b0;
      m[i].done    = 1'b0;
      m[i].t       = 0;
      m[i].run_end = -1;
      m[i].rc      = '0;
    end
  endfunction

  function automatic void model_step(input int i, input bit start, input bit halt);
    int rs;
    rs = p_l[i] + 4;
    if (m[i].done) begin
      if (!start) m[i].done = 1'b0;
    end else if (!m[i].active) begin
      if (start) begin
        m[i].active  = 1'b1;
        m[i].t       = 1;
        m[i].run_end = -1;
      end
    end else begin
      if (m[i].t >= rs && m[i].run_end < 0) begin
        m[i].rc = m[i].rc + 32'd1;
        if ((p_r[i] != 0 && m[i].rc == 32'(p_r[i])) || halt) m[i].run_end = m[i].t;
      end
      m[i].t = m[i].t + 1;
      if (m[i].t == p_l[i] + 3) m[i].rc = '0;
      if (m[i].run_end >= 0 && m[i].t == m[i].run_end + 1 + p_d[i]) begin
        m[i].active = 1'b0;
        m[i].done   = 1'b1;
      end
    end
  endfunction

  // Expected {mem, load, core, pc, pipe, dump, busy, done}.
  function automatic logic [7:0] model_out(input int i);
    logic [7:0] v;
    int t, l;
    v = '0;
    t = m[i].t;
    l = p_l[i];
    if (m[i].done) v[0] = 1'b1;
    if (m[i].active) begin
      v[1] = 1'b1;
      v[7] = (t == 1);
      v[6] = (t >= 2) && (t <= 1 + l);
      v[5] = (t == 2 + l);
      v[4] = (t == 3 + l);
      v[3] = (t >= 4 + l) && (m[i].run_end < 0 || t <= m[i].run_end);
      v[2] = (m[i].run_end >= 0) && (t > m[i].run_end) && (t <= m[i].run_end + p_d[i]);
    end
    return v;
  endfunction

  // Model advances on the same edges as the DUT; reset is asynchronous.
  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        model_reset();
      end else begin
        model_step(0, start_a, halt_a);
        model_step(1, start_b, halt_b);
      end
    end
  end

  // Single compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge CLK);
      check("outs_a", {mem_a, load_a, core_a, pc_a, pipe_a, dump_a, busy_a, done_a}, model_out(0));
      check("rc_a", rc_a, m[0].rc);
      check("onehot_a", ($countones({mem_a, load_a, core_a, pc_a, pipe_a, dump_a}) <= 1), 1);
      check("outs_b", {mem_b, load_b, core_b, pc_b, pipe_b, dump_b, busy_b, done_b}, model_out(1));
      check("rc_b", rc_b, m[1].rc);
      check("onehot_b", ($countones({mem_b, load_b, core_b, pc_b, pipe_b, dump_b}) <= 1), 1);
    end
  end

  // ---------------- directed scenarios with literal expectations ----------------
  // Hand-written timeline for A: {mem, load, core, pc, pipe, dump, done} in cycles 1..12.
  logic [6:0] nom_tab [12];

  task automatic wait_done_a(input string name);
    int c;
    c = 0;
    while (!done_a && c < 100) begin
      @(negedge CLK);
      c++;
    end
    check(name, done_a, 1'b1);
  endtask

  task automatic run_nominal(input bit noisy, input string name);
    if (noisy) begin
      halt_a = 1'b1;
      @(negedge CLK);
      halt_a = 1'b0;
    end
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge CLK);
      check(name, {mem_a, load_a, core_a, pc_a, pipe_a, dump_a, done_a}, nom_tab[c-1]);
      if (noisy) begin
        start_a = (c == 2 || c == 6 || c == 8) ? 1'b1 : 1'b0;
        halt_a  = (c == 2 || c == 3 || c == 11) ? 1'b1 : 1'b0;
      end
    end
    start_a = 1'b0;
    halt_a  = 1'b0;
    check({name, "_rc"}, rc_a, 32'd5);
    @(negedge CLK);
    check({name, "_idle"}, {busy_a, done_a}, 2'b00);
  endtask

  task automatic run_halt(input int k, input int exp_pipe, input string name);
    int np, nd, c;
    np = 0;
    nd = 0;
    c  = 1;
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    while (!done_a && c < 40) begin
      halt_a = (c == 5 + k);
      if (pipe_a) np++;
      if (dump_a) nd++;
      @(negedge CLK);
      c++;
    end
    halt_a = 1'b0;
    check({name, "_pipe"}, np, exp_pipe);
    check({name, "_dump"}, nd, 1);
    check({name, "_rc"}, rc_a, exp_pipe);
    @(negedge CLK);
  endtask

  initial begin
    int np;
    nom_tab = '{7'b1000000, 7'b0100000, 7'b0100000, 7'b0010000, 7'b0001000,
                7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100,
                7'b0000010, 7'b0000001};
    RESET_N = 1'b0;
    start_a = 1'b0; halt_a = 1'b0; start_b = 1'b0; halt_b = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outs_a", {mem_a, load_a, core_a, pc_a, pipe_a, dump_a, busy_a, done_a}, 8'h00);
    check("reset_rc_a", rc_a, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Nominal, then the same with START/HALT noise where they must be ignored.
    run_nominal(1'b0, "nominal");
    run_nominal(1'b1, "ignored_inputs");

    // HALT at the 3rd RUN edge, then at the 5th (coincides with the limit).
    run_halt(3, 3, "halt3");
    run_halt(5, 5, "halt5");

    // Unbounded instance: HALT on the 1000th RUN cycle.
    start_b = 1'b1;
    @(negedge CLK);
    start_b = 1'b0;
    np = 0;
    for (int c = 0; c < 1200; c++) begin
      if (pipe_b) np++;
      if (np == 1000) break;
      @(negedge CLK);
    end
    halt_b = 1'b1;
    @(negedge CLK);
    halt_b = 1'b0;
    check("unbounded_pipe", np, 1000);
    check("unbounded_dump", dump_b, 1'b1);
    check("unbounded_rc", rc_b, 32'd1000);
    repeat (3) @(negedge CLK);

    // Reset in the middle of RUN (cycle 8), checked before the next edge.
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (7) @(negedge CLK);
    check("pre_abort_pipe", pipe_a, 1'b1);
    #1 RESET_N = 1'b0;
    #1;
    check("abort_outs_a", {mem_a, load_a, core_a, pc_a, pipe_a, dump_a, busy_a, done_a}, 8'h00);
    check("abort_rc_a", rc_a, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Restart with START held high all the way into DONE.
    start_a = 1'b1;
    @(negedge CLK);
    check("restart_mem", mem_a, 1'b1);
    wait_done_a("restart_done");
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      check("done_hold", done_a, 1'b1);
    end
    start_a = 1'b0;
    @(negedge CLK);
    start_a = 1'b1;
    @(negedge CLK);
    check("second_mem", mem_a, 1'b1);
    start_a = 1'b0;
    repeat (4) @(negedge CLK);
    check("second_rc_clear", {pc_a, rc_a}, {1'b1, 32'd0});
    wait_done_a("second_done");
    check("second_rc", rc_a, 32'd5);
    @(negedge CLK);

    // Randomized phase: all checking by the model in the compare process.
    for (int n = 0; n < 2000; n++) begin
      start_a = ($urandom_range(0, 7) == 0);
      halt_a  = ($urandom_range(0, 9) == 0);
      start_b = ($urandom_range(0, 7) == 0);
      halt_b  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    start_a = 1'b0; halt_a = 1'b0; start_b = 1'b0; halt_b = 1'b0;
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
